// File: rtl/sleep_ctrl.sv
// Core sleep controller: drains the pipeline on WFI, requests clock gating
// while asleep, and sequences a fixed-length wake-up before fetch resumes.
// Moore FSM; stall/sleep outputs are decoded from the state register only.
module sleep_ctrl #(
   parameter int unsigned WAKE_CYCLES   = 4,    // 1..15
   parameter int unsigned DRAIN_TIMEOUT = 255   // 2..255
) (
   input  logic        clk_i,
   input  logic        rst_n,
   input  logic        wfi_req_i,
   input  logic        pipe_empty_i,
   input  logic        lsu_busy_i,
   input  logic        irq_pending_i,
   input  logic        debug_req_i,
   input  logic        clr_err_i,
   output logic        stall_fetch_o,
   output logic        core_sleep_o,
   output logic        wfi_ack_o,
   output logic [1:0]  state_o,
   output logic        timeout_err_o,
   output logic [15:0] sleep_cnt_o
);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_SLEEP = 2'd2;
   localparam logic [1:0] ST_WAKE  = 2'd3;

   // Last drain count value before the attempt is abandoned.
   localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_TIMEOUT - 1);
   localparam logic [3:0] WAKE_LOAD  = 4'(WAKE_CYCLES);

   logic [1:0]  r_state;
   logic [7:0]  r_drain_cnt;
   logic [3:0]  r_wake_cnt;
   logic        r_qual;        // qualify was seen at the previous DRAIN edge
   logic        r_ack;
   logic        r_err;
   logic [15:0] r_sleep_cnt;

   logic        w_wake;
   logic        w_qualify;
   logic [1:0]  w_state_nxt;
   logic [7:0]  w_drain_nxt;
   logic [3:0]  w_wake_nxt;
   logic        w_qual_nxt;
   logic        w_ack_evt;
   logic        w_timeout;
   logic        w_sleep_entry;

   assign w_wake    = irq_pending_i | debug_req_i;
   assign w_qualify = pipe_empty_i & ~lsu_busy_i;

   // Next-state, counter and event decode for the sleep FSM.
   always_comb begin
      w_state_nxt   = r_state;
      w_drain_nxt   = r_drain_cnt;
      w_wake_nxt    = r_wake_cnt;
      w_qual_nxt    = r_qual;
      w_ack_evt     = 1'b0;
      w_timeout     = 1'b0;
      w_sleep_entry = 1'b0;
      case (r_state)
         ST_RUN: begin
            // Counters are held cleared so every DRAIN starts from zero.
            w_drain_nxt = 8'd0;
            w_wake_nxt  = 4'd0;
            w_qual_nxt  = 1'b0;
            if (wfi_req_i) begin
               if (w_wake) begin
                  // WFI with a wake source already pending behaves as a NOP.
                  w_ack_evt = 1'b1;
               end else begin
                  w_state_nxt = ST_DRAIN;
               end
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (w_wake) begin
               w_state_nxt = ST_RUN;
               w_ack_evt   = 1'b1;
               w_drain_nxt = 8'd0;
               w_qual_nxt  = 1'b0;
            end else if (w_qualify && r_qual) begin
               w_state_nxt   = ST_SLEEP;
               w_sleep_entry = 1'b1;
               w_drain_nxt   = 8'd0;
               w_qual_nxt    = 1'b0;
            end else if (r_drain_cnt == DRAIN_LAST) begin
               w_state_nxt = ST_RUN;
               w_ack_evt   = 1'b1;
               w_timeout   = 1'b1;
               w_drain_nxt = 8'd0;
               w_qual_nxt  = 1'b0;
            end else begin
               w_drain_nxt = r_drain_cnt + 8'd1;
               w_qual_nxt  = w_qualify;
            end
         end
         ST_SLEEP: begin
            if (w_wake) begin
               w_state_nxt = ST_WAKE;
               w_wake_nxt  = WAKE_LOAD;
            end else begin
               w_state_nxt = ST_SLEEP;
            end
         end
         ST_WAKE: begin
            // Wake sources are deliberately not looked at here.
            if (r_wake_cnt <= 4'd1) begin
               w_state_nxt = ST_RUN;
               w_ack_evt   = 1'b1;
               w_wake_nxt  = 4'd0;
            end else begin
               w_wake_nxt = r_wake_cnt - 4'd1;
            end
         end
         default: begin
            w_state_nxt = ST_RUN;
            w_drain_nxt = 8'd0;
            w_wake_nxt  = 4'd0;
            w_qual_nxt  = 1'b0;
         end
      endcase
   end

   // State, counters, ack pulse, sticky error and sleep-entry counter.
   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         r_state     <= ST_RUN;
         r_drain_cnt <= 8'd0;
         r_wake_cnt  <= 4'd0;
         r_qual      <= 1'b0;
         r_ack       <= 1'b0;
         r_err       <= 1'b0;
         r_sleep_cnt <= 16'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_drain_cnt <= w_drain_nxt;
         r_wake_cnt  <= w_wake_nxt;
         r_qual      <= w_qual_nxt;
         // Suppressing back-to-back events keeps the ack a single-cycle pulse.
         r_ack       <= w_ack_evt & ~r_ack;
         if (w_timeout) begin
            r_err <= 1'b1;
         end else if (clr_err_i) begin
            r_err <= 1'b0;
         end else begin
            r_err <= r_err;
         end
         if (w_sleep_entry && (r_sleep_cnt != 16'hFFFF)) begin
            r_sleep_cnt <= r_sleep_cnt + 16'd1;
         end
      end
   end

   assign state_o       = r_state;
   assign stall_fetch_o = (r_state != ST_RUN);
   assign core_sleep_o  = (r_state == ST_SLEEP);
   assign wfi_ack_o     = r_ack;
   assign timeout_err_o = r_err;
   assign sleep_cnt_o   = r_sleep_cnt;

endmodule

// File: tb/tb_sleep_ctrl.sv
// Bench for sleep_ctrl: two instances (long and short drain timeout) share
// the same stimulus; a cycle-level behavioural model of the controller rules
// is checked against both on every cycle, plus literal scenario checks.
module tb_sleep_ctrl;

   localparam int WC = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, wfi, pe, lsu, irq, dbg, clr;
   logic        stall [2];
   logic        slp   [2];
   logic        ack   [2];
   logic [1:0]  st    [2];
   logic        err   [2];
   logic [15:0] cnt   [2];

   sleep_ctrl #(.WAKE_CYCLES(WC), .DRAIN_TIMEOUT(255)) dut0 (
      .clk_i(clk), .rst_n(rst_n), .wfi_req_i(wfi), .pipe_empty_i(pe),
      .lsu_busy_i(lsu), .irq_pending_i(irq), .debug_req_i(dbg),
      .clr_err_i(clr), .stall_fetch_o(stall[0]), .core_sleep_o(slp[0]),
      .wfi_ack_o(ack[0]), .state_o(st[0]), .timeout_err_o(err[0]),
      .sleep_cnt_o(cnt[0]));

   sleep_ctrl #(.WAKE_CYCLES(WC), .DRAIN_TIMEOUT(8)) dut1 (
      .clk_i(clk), .rst_n(rst_n), .wfi_req_i(wfi), .pipe_empty_i(pe),
      .lsu_busy_i(lsu), .irq_pending_i(irq), .debug_req_i(dbg),
      .clr_err_i(clr), .stall_fetch_o(stall[1]), .core_sleep_o(slp[1]),
      .wfi_ack_o(ack[1]), .state_o(st[1]), .timeout_err_o(err[1]),
      .sleep_cnt_o(cnt[1]));

   // ---------------- behavioural model ----------------
   // Mode numbering follows the published state_o values.
   int m_state  [2] = '{0, 0};
   int m_entry  [2] = '{0, 0};   // edge index at which current mode was entered
   int m_streak [2] = '{0, 0};   // consecutive qualified DRAIN edges
   int m_cnt    [2] = '{0, 0};
   bit m_err    [2] = '{1'b0, 1'b0};
   bit m_ack    [2] = '{1'b0, 1'b0};
   int m_limit  [2] = '{255, 8};
   int m_cyc = 0;
   bit preload = 1'b0;

   // Advance the model by one clock edge using the inputs seen at that edge.
   always @(posedge clk) begin : model
      bit wk, ev, tmo;
      int nxt, age;
      m_cyc = m_cyc + 1;
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            m_state[i] = 0; m_err[i] = 1'b0; m_ack[i] = 1'b0;
            m_cnt[i] = 0; m_streak[i] = 0; m_entry[i] = m_cyc;
         end else begin
            if (i == 0 && preload) m_cnt[0] = 65534;
            wk  = irq | dbg;
            ev  = 1'b0;
            tmo = 1'b0;
            nxt = m_state[i];
            age = m_cyc - m_entry[i];   // cycles spent in the mode so far
            case (m_state[i])
               0: if (wfi) begin
                     if (wk) ev = 1'b1; else nxt = 1;
                  end
               1: begin
                     m_streak[i] = (pe && !lsu) ? m_streak[i] + 1 : 0;
                     if (wk) begin
                        nxt = 0; ev = 1'b1;
                     end else if (m_streak[i] >= 2) begin
                        nxt = 2;
                        if (m_cnt[i] < 65535) m_cnt[i] = m_cnt[i] + 1;
                     end else if (age >= m_limit[i]) begin
                        nxt = 0; ev = 1'b1; tmo = 1'b1;
                     end
                  end
               2: if (wk) nxt = 3;
               default: if (age >= WC) begin
                     nxt = 0; ev = 1'b1;
                  end
            endcase
            if (tmo) m_err[i] = 1'b1;
            else if (clr) m_err[i] = 1'b0;
            m_ack[i] = ev && !m_ack[i];
            if (nxt != m_state[i]) begin
               m_entry[i]  = m_cyc;
               m_streak[i] = 0;
            end
            m_state[i] = nxt;
         end
      end
   end

   // ---------------- checking ----------------
   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("state%0d", i), int'(st[i]), m_state[i]);
         chk($sformatf("stall%0d", i), int'(stall[i]), (m_state[i] != 0) ? 1 : 0);
         chk($sformatf("sleep%0d", i), int'(slp[i]), (m_state[i] == 2) ? 1 : 0);
         chk($sformatf("ack%0d", i), int'(ack[i]), int'(m_ack[i]));
         chk($sformatf("err%0d", i), int'(err[i]), int'(m_err[i]));
         chk($sformatf("cnt%0d", i), int'(cnt[i]), m_cnt[i]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic drive(input bit w, input bit p, input bit l,
                        input bit q, input bit d, input bit c);
      wfi = w; pe = p; lsu = l; irq = q; dbg = d; clr = c;
      tick();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0;
      wfi = 1'b0; pe = 1'b0; lsu = 1'b0; irq = 1'b0; dbg = 1'b0; clr = 1'b0;
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0);
      chk("rst_state", int'(st[0]), 0);
      chk("rst_stall", int'(stall[0]), 0);
      chk("rst_cnt", int'(cnt[0]), 0);
      chk("rst_err", int'(err[1]), 0);
      rst_n = 1'b1;
      drive(0, 1, 0, 0, 0, 0);

      // Basic sleep/wake: 2 DRAIN, 10 SLEEP, 4 WAKE, ack, count 1.
      drive(1, 1, 0, 0, 0, 0);
      chk("wfi_stall", int'(stall[0]), 1);
      chk("wfi_drain", int'(st[0]), 1);
      drive(0, 1, 0, 0, 0, 0);
      chk("drain1", int'(st[0]), 1);
      drive(0, 1, 0, 0, 0, 0);
      chk("sleep_in", int'(st[0]), 2);
      chk("sleep_out", int'(slp[0]), 1);
      chk("sleep_cnt1", int'(cnt[0]), 1);
      chk("model_sleep", m_state[0], 2);
      for (int k = 0; k < 9; k++) drive(0, 1, 0, 0, 0, 0);
      chk("still_sleep", int'(st[0]), 2);
      drive(0, 1, 0, 1, 0, 0);
      chk("wake_in", int'(st[0]), 3);
      chk("wake_nosleep", int'(slp[0]), 0);
      for (int k = 0; k < WC - 1; k++) drive(0, 1, 0, 0, 0, 0);
      chk("wake_last", int'(st[0]), 3);
      drive(0, 1, 0, 0, 0, 0);
      chk("wake_run", int'(st[0]), 0);
      chk("wake_ack", int'(ack[0]), 1);
      chk("model_ack", int'(m_ack[0]), 1);
      drive(0, 1, 0, 0, 0, 0);
      chk("ack_once", int'(ack[0]), 0);

      // WFI with irq pending acts as NOP.
      drive(1, 1, 0, 1, 0, 0);
      chk("nop_state", int'(st[0]), 0);
      chk("nop_stall", int'(stall[0]), 0);
      chk("nop_ack", int'(ack[0]), 1);
      drive(0, 1, 0, 0, 0, 0);
      chk("nop_ack_off", int'(ack[0]), 0);

      // LSU drain with a one-cycle qualify glitch at DRAIN cycle 3.
      drive(1, 1, 0, 0, 0, 0);
      for (int c = 1; c <= 7; c++) drive(0, 1, (c != 3), 0, 0, 0);
      chk("lsu_hold", int'(st[0]), 1);
      drive(0, 1, 0, 0, 0, 0);
      chk("lsu_q1", int'(st[0]), 1);
      drive(0, 1, 0, 0, 0, 0);
      chk("lsu_sleep", int'(st[0]), 2);
      chk("lsu_short_to", int'(err[1]), 1);
      drive(0, 1, 0, 1, 0, 0);
      for (int k = 0; k < WC + 1; k++) drive(0, 1, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0, 1);

      // Drain timeout on the short-timeout instance.
      drive(1, 0, 0, 0, 0, 0);
      for (int c = 1; c <= 7; c++) drive(0, 0, 0, 0, 0, 0);
      chk("to_hold", int'(st[1]), 1);
      drive(0, 0, 0, 0, 0, 0);
      chk("to_run", int'(st[1]), 0);
      chk("to_err", int'(err[1]), 1);
      chk("to_ack", int'(ack[1]), 1);
      chk("model_err", int'(m_err[1]), 1);
      drive(0, 0, 0, 0, 0, 1);
      chk("to_clr", int'(err[1]), 0);
      // Timeout coincident with clear: the flag stays set.
      drive(1, 0, 0, 0, 0, 0);
      for (int c = 1; c <= 7; c++) drive(0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 1);
      chk("to_clr_same", int'(err[1]), 1);
      drive(0, 0, 0, 0, 1, 1);
      drive(0, 0, 0, 0, 0, 0);

      // Abort in DRAIN via debug request at DRAIN cycle 1.
      drive(1, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 1, 0);
      chk("abort_run", int'(st[0]), 0);
      chk("abort_ack", int'(ack[0]), 1);
      chk("abort_nosleep", int'(slp[0]), 0);
      drive(0, 0, 0, 0, 0, 0);

      // Reset while in SLEEP.
      drive(1, 1, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0, 0);
      chk("pre_rst_sleep", int'(st[0]), 2);
      rst_n = 1'b0;
      drive(0, 1, 0, 0, 0, 0);
      chk("rst_sl_state", int'(st[0]), 0);
      chk("rst_sl_sleep", int'(slp[0]), 0);
      chk("rst_sl_cnt", int'(cnt[0]), 0);
      rst_n = 1'b1;
      drive(0, 1, 0, 0, 0, 0);

      // Saturation: preload the entry counter just below full scale.
      #1;
      force dut0.r_sleep_cnt = 16'hFFFE;
      preload = 1'b1;
      tick();
      preload = 1'b0;
      release dut0.r_sleep_cnt;
      drive(0, 1, 0, 0, 0, 0);
      chk("pre_sat", int'(cnt[0]), 65534);
      for (int r = 0; r < 2; r++) begin
         drive(1, 1, 0, 0, 0, 0);
         drive(0, 1, 0, 0, 0, 0);
         drive(0, 1, 0, 0, 0, 0);
         chk($sformatf("sat%0d", r), int'(cnt[0]), 65535);
         drive(0, 1, 0, 1, 0, 0);
         for (int k = 0; k < WC + 1; k++) drive(0, 1, 0, 0, 0, 0);
      end

      // Randomized traffic, including occasional resets.
      for (int n = 0; n < 4000; n++) begin
         rst_n = ($urandom_range(0, 199) != 0);
         drive(($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0),
               ($urandom_range(0, 39) == 0), ($urandom_range(0, 11) == 0));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
